// File: rtl/gpu_mem_responder.sv
// Word RAM plus framebuffer FIFO/STATUS MMIO; optional sticky err for bad writes under GPU_MEM_ACCESS_ERR_EN.
// Reads are combinational and writes commit at the clk edge; fb_data/fb_valid hold while !fb_ready and pushes to a full FIFO are dropped.
module gpu_mem_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  output logic [31:0] rd_data,
  output logic [31:0] fb_data,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic        err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0]   RAM_BYTES = 32'(4 * RAM_WORDS);
  localparam logic [31:0]   STAT_ADDR = MMIO_BASE + 32'd4;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  logic [31:0]   ram      [RAM_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic        sel_ram;
  logic        sel_fifo;
  logic        sel_stat;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_req;
  logic        push_ok;
  logic        push_rej;
  logic        ovf_clr;
  logic [31:0] status;

  // Low two address bits are don't-care for the MMIO registers.
  assign sel_ram  = (address < RAM_BYTES);
  assign sel_fifo = (address[31:2] == MMIO_BASE[31:2]);
  assign sel_stat = (address[31:2] == STAT_ADDR[31:2]);

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign fb_valid = !empty;
  assign fb_data  = empty ? 32'h0 : fifo_mem[rd_ptr];
  assign pop      = fb_valid && fb_ready;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_req = wr_en && sel_fifo;
  assign push_ok  = push_req && (!full || pop);
  assign push_rej = push_req && !push_ok;
  assign ovf_clr  = wr_en && sel_stat && wr_data[2];

  assign status = {16'h0, 8'(count), 5'h0, overflow, full, empty};

  always_comb begin
    rd_data = 32'h0;
    if (!reset) begin
      if (sel_ram)       rd_data = ram[address[AW+1:2]];
      else if (sel_stat) rd_data = status;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en && sel_ram) ram[address[AW+1:2]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
      // A rejected push outranks a software clear in the same cycle.
      if (push_rej)     overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef GPU_MEM_ACCESS_ERR_EN
  logic unmapped;
  logic err_set;
  logic err_q;

  assign unmapped = !(sel_ram || sel_fifo || sel_stat);
  assign err_set  = (wr_en && unmapped) || push_rej;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Directed bench for gpu_mem_responder: vector table for RAM/FIFO basics, hand sequences for overflow, full-pass-through, reset and err.
module tb_gpu_mem_responder;

  localparam logic [31:0] B = 32'h8000_0000;
  localparam logic [31:0] S = 32'h8000_0004;
`ifdef GPU_MEM_ACCESS_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] rd_data;
  logic [31:0] fb_data;
  logic        fb_valid;
  logic        fb_ready;
  logic        err;

  int tests = 0;
  int fails = 0;

  gpu_mem_responder #(.RAM_WORDS(1024), .FIFO_DEPTH(16), .MMIO_BASE(32'h8000_0000)) dut (
    .clk(clk), .reset(reset), .address(address), .wr_data(wr_data), .wr_en(wr_en),
    .rd_data(rd_data), .fb_data(fb_data), .fb_valid(fb_valid), .fb_ready(fb_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [31:0] a, logic [31:0] wd, logic we, logic rdy,
                              logic chk, logic [31:0] er, logic ev, logic [31:0] ed);
    vec_t v;
    v.addr = a; v.wdata = wd; v.wen = we; v.rdy = rdy;
    v.chk_rd = chk; v.exp_rd = er; v.exp_v = ev; v.exp_d = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one bus cycle at the falling edge; outputs are sampled 2ns later, before the committing rising edge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic rdy);
    @(negedge clk);
    address = a; wr_data = wd; wr_en = we; fb_ready = rdy;
    #2;
  endtask

  initial begin
    reset = 1'b1; address = 32'h10; wr_data = '0; wr_en = 1'b0; fb_ready = 1'b0;

    // RAM preload/readback, FIFO address reads, unmapped reads, then push 1,2,3 and drain.
    tv.push_back(mk(32'h14, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0));
    tv.push_back(mk(32'h10, 32'hDEADBEEF, 1, 0, 0, 32'h0,        0, 32'h0));
    tv.push_back(mk(32'h10, 32'h0,        0, 0, 1, 32'hDEADBEEF, 0, 32'h0));
    tv.push_back(mk(32'h13, 32'h0,        0, 0, 1, 32'hDEADBEEF, 0, 32'h0));
    tv.push_back(mk(32'h14, 32'h0,        0, 0, 1, 32'h0,        0, 32'h0));
    tv.push_back(mk(32'h20, 32'h11111111, 1, 0, 0, 32'h0,        0, 32'h0));
    tv.push_back(mk(32'h20, 32'hCAFEF00D, 1, 0, 1, 32'h11111111, 0, 32'h0));
    tv.push_back(mk(32'h20, 32'h0,        0, 0, 1, 32'hCAFEF00D, 0, 32'h0));
    tv.push_back(mk(32'h4000_0000, 32'h0, 0, 0, 1, 32'h0,        0, 32'h0));
    tv.push_back(mk(B,      32'h0,        0, 0, 1, 32'h0,        0, 32'h0));
    tv.push_back(mk(B + 32'd8, 32'h0,     0, 0, 1, 32'h0,        0, 32'h0));
    tv.push_back(mk(S,      32'h0,        0, 0, 1, 32'h1,        0, 32'h0));
    tv.push_back(mk(S,      32'hFFFF_FFFB, 1, 0, 1, 32'h1,       0, 32'h0));
    tv.push_back(mk(S,      32'h0,        0, 0, 1, 32'h1,        0, 32'h0));
    tv.push_back(mk(B,      32'h1,        1, 0, 1, 32'h0,        0, 32'h0));
    tv.push_back(mk(B,      32'h2,        1, 0, 1, 32'h0,        1, 32'h1));
    tv.push_back(mk(B,      32'h3,        1, 0, 1, 32'h0,        1, 32'h1));
    tv.push_back(mk(S,      32'h0,        0, 0, 1, 32'h300,      1, 32'h1));
    tv.push_back(mk(S,      32'h0,        0, 1, 1, 32'h300,      1, 32'h1));
    tv.push_back(mk(S,      32'h0,        0, 1, 1, 32'h200,      1, 32'h2));
    tv.push_back(mk(S,      32'h0,        0, 1, 1, 32'h100,      1, 32'h3));
    tv.push_back(mk(S,      32'h0,        0, 1, 1, 32'h1,        0, 32'h0));

    #2;
    check("reset_fb_valid", {31'h0, fb_valid}, 32'h0);
    check("reset_fb_data", fb_data, 32'h0);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].addr, tv[i].wdata, tv[i].wen, tv[i].rdy);
      if (tv[i].chk_rd) check($sformatf("vec%0d_rd_data", i), rd_data, tv[i].exp_rd);
      check($sformatf("vec%0d_fb_valid", i), {31'h0, fb_valid}, {31'h0, tv[i].exp_v});
      check($sformatf("vec%0d_fb_data", i), fb_data, tv[i].exp_d);
    end
    check("err_after_unmapped_read", {31'h0, err}, 32'h0);

    // Overflow: 17 pushes into a 16-deep FIFO, then software clear.
    for (int i = 0; i < 17; i++) step(B, 32'h100 + i, 1'b1, 1'b0);
    step(S, 32'h0, 1'b0, 1'b0);
    check("ovf_status", rd_data, 32'h0000_1006);
    check("ovf_head_stable", fb_data, 32'h100);
    step(S, 32'h4, 1'b1, 1'b0);
    check("ovf_clr_cycle_status", rd_data, 32'h0000_1006);
    step(S, 32'h0, 1'b0, 1'b0);
    check("ovf_cleared_status", rd_data, 32'h0000_1002);

    // Full FIFO, push while the head pops: accepted, new word drains last.
    step(B, 32'h999, 1'b1, 1'b1);
    check("full_pass_head", fb_data, 32'h100);
    step(S, 32'h0, 1'b0, 1'b0);
    check("full_pass_status", rd_data, 32'h0000_1002);
    for (int i = 0; i < 16; i++) begin
      step(S, 32'h0, 1'b0, 1'b1);
      check($sformatf("drain%0d_valid", i), {31'h0, fb_valid}, 32'h1);
      check($sformatf("drain%0d_data", i), fb_data, (i < 15) ? 32'h101 + i : 32'h999);
    end
    step(S, 32'h0, 1'b0, 1'b0);
    check("drained_status", rd_data, 32'h1);

    // Asynchronous reset in the first drain cycle with 5 words queued.
    for (int i = 0; i < 5; i++) step(B, 32'h51 + i, 1'b1, 1'b0);
    @(negedge clk);
    address = S; wr_en = 1'b0; fb_ready = 1'b1;
    #1;
    check("pre_reset_head", fb_data, 32'h51);
    check("pre_reset_status", rd_data, 32'h0000_0500);
    reset = 1'b1;
    #1;
    check("async_reset_fb_valid", {31'h0, fb_valid}, 32'h0);
    check("async_reset_fb_data", fb_data, 32'h0);
    check("async_reset_rd_data", rd_data, 32'h0);
    check("async_reset_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(S, 32'h0, 1'b0, 1'b0);
    check("post_reset_status", rd_data, 32'h1);
    step(32'h10, 32'h0, 1'b0, 1'b0);
    check("post_reset_ram", rd_data, 32'hDEADBEEF);

    // Sticky err on unmapped write; unmapped read leaves it alone.
    step(32'h4000_0000, 32'h0, 1'b0, 1'b0);
    step(32'h4000_0000, 32'h0, 1'b0, 1'b0);
    check("err_unmapped_read", {31'h0, err}, 32'h0);
    step(32'h4000_0000, 32'hABC, 1'b1, 1'b0);
    check("err_before_edge", {31'h0, err}, 32'h0);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    check("err_after_write", {31'h0, err}, {31'h0, ERR_EXP});
    for (int i = 0; i < 3; i++) begin
      step(32'h4000_0000, 32'h0, 1'b0, 1'b0);
      check($sformatf("err_sticky%0d", i), {31'h0, err}, {31'h0, ERR_EXP});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
